// File: rtl/wb_port_arbiter_if.sv
// Purpose: bundles the pipeline write-back, multi-cycle result and register-file
//          write-port signals of wb_port_arbiter into one connection.
// Ports:   pipe_* (write-back in), mc_* (valid/ready result in), rf_* (write out),
//          pend_mask_o (queued-destination mask), stall_o (issue-stall request).
interface wb_port_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int RWIDTH = 5
);
    logic                   pipe_we_i;
    logic [RWIDTH-1:0]      pipe_rd_i;
    logic [DWIDTH-1:0]      pipe_data_i;
    logic                   mc_valid_i;
    logic                   mc_ready_o;
    logic [RWIDTH-1:0]      mc_rd_i;
    logic [DWIDTH-1:0]      mc_data_i;
    logic                   rf_we_o;
    logic [RWIDTH-1:0]      rf_rd_o;
    logic [DWIDTH-1:0]      rf_data_o;
    logic [2**RWIDTH-1:0]   pend_mask_o;
    logic                   stall_o;

    // Arbiter side.
    modport slave (
        input  pipe_we_i, pipe_rd_i, pipe_data_i,
        input  mc_valid_i, mc_rd_i, mc_data_i,
        output mc_ready_o,
        output rf_we_o, rf_rd_o, rf_data_o,
        output pend_mask_o, stall_o
    );

    // Requester / register-file side.
    modport master (
        output pipe_we_i, pipe_rd_i, pipe_data_i,
        output mc_valid_i, mc_rd_i, mc_data_i,
        input  mc_ready_o,
        input  rf_we_o, rf_rd_o, rf_data_o,
        input  pend_mask_o, stall_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Purpose: arbitrates the single register-file write port between pipeline
//          write-back (always wins) and buffered multi-cycle results.
// Latency: 1 cycle from winning request to rf_* (registered outputs).
// Backpressure: mc_ready_o drops while the result FIFO is full; pipeline has
//          none, but stall_o asks it to pause when a queued result starves.
// Ports:   clk, reset (async, active-low), bus (wb_port_arbiter_if.slave).
module wb_port_arbiter #(
    parameter int DWIDTH     = 32,
    parameter int RWIDTH     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    wb_port_arbiter_if.slave    bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(STARVE_MAX + 1);
    localparam int NREG = 2**RWIDTH;

    typedef enum logic {RUN, STALL} state_t;

    // FIFO storage and bookkeeping
    logic [RWIDTH-1:0]  rd_mem   [FIFO_DEPTH];
    logic [DWIDTH-1:0]  data_mem [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      age_q, age_d;
    state_t             state_q, state_d;

    logic               rf_we_q, rf_we_d;
    logic [RWIDTH-1:0]  rf_rd_q, rf_rd_d;
    logic [DWIDTH-1:0]  rf_data_q, rf_data_d;

    logic fifo_empty, mc_xfer, pipe_wr, pop, bypass, push;

    assign fifo_empty = (count_q == '0);
    assign bus.mc_ready_o = (count_q != CW'(FIFO_DEPTH));
    assign mc_xfer    = bus.mc_valid_i & bus.mc_ready_o;
    // Writes to x0 are architecturally invisible, so they never claim the port.
    assign pipe_wr    = bus.pipe_we_i & (bus.pipe_rd_i != '0);
    assign pop        = ~pipe_wr & ~fifo_empty;
    // Skip the FIFO entirely when it is empty and the port is free this cycle.
    assign bypass     = ~pipe_wr & fifo_empty & mc_xfer & (bus.mc_rd_i != '0);
    // x0 results are accepted (handshake completes) but dropped here.
    assign push       = mc_xfer & (bus.mc_rd_i != '0) & ~bypass;

    assign count_d = count_q + CW'(push) - CW'(pop);

    // Write-port selection, fixed priority: pipe, FIFO head, bypass.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (pipe_wr) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = bus.pipe_rd_i;
            rf_data_d = bus.pipe_data_i;
        end else if (pop) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = rd_mem[rd_ptr_q];
            rf_data_d = data_mem[rd_ptr_q];
        end else if (bypass) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = bus.mc_rd_i;
            rf_data_d = bus.mc_data_i;
        end
    end

    // Age of the current head: cycles it has waited without draining.
    always_comb begin
        age_d = age_q;
        if (fifo_empty || pop) begin
            age_d = '0;
        end else if (age_q != AW'(STARVE_MAX)) begin
            age_d = age_q + AW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (age_q == AW'(STARVE_MAX)) state_d = STALL;
            STALL:   if (fifo_empty)               state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // One bit per queued destination; slot i is live when its distance from
    // the read pointer is below the occupancy count.
    always_comb begin
        logic [PW-1:0] off;
        off = '0;
        bus.pend_mask_o = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (CW'(off) < count_q) begin
                bus.pend_mask_o[rd_mem[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            age_q     <= '0;
            state_q   <= RUN;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            count_q   <= count_d;
            age_q     <= age_d;
            state_q   <= state_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= bus.mc_rd_i;
            data_mem[wr_ptr_q] <= bus.mc_data_i;
        end
    end

    assign bus.rf_we_o   = rf_we_q;
    assign bus.rf_rd_o   = rf_rd_q;
    assign bus.rf_data_o = rf_data_q;
    assign bus.stall_o   = (state_q == STALL);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Purpose: directed checks of wb_port_arbiter priority, bypass, FIFO fill,
//          starvation stall, x0 handling and mid-operation reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_port_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wb_port_arbiter_if #(.DWIDTH(32), .RWIDTH(5)) bus ();

    wb_port_arbiter #(
        .DWIDTH(32), .RWIDTH(5), .FIFO_DEPTH(4), .STARVE_MAX(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.pipe_we_i   = 1'b0;
        bus.pipe_rd_i   = '0;
        bus.pipe_data_i = '0;
        bus.mc_valid_i  = 1'b0;
        bus.mc_rd_i     = '0;
        bus.mc_data_i   = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h want 0", bus.rf_we_o); end
        checks++; if (bus.rf_rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0h want 0", bus.rf_rd_o); end
        checks++; if (bus.rf_data_o !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", bus.rf_data_o); end
        checks++; if (bus.pend_mask_o !== 32'd0) begin errors++; $display("FAIL reset_pend: got %0h want 0", bus.pend_mask_o); end
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h want 0", bus.stall_o); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.mc_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h want 1", bus.mc_ready_o); end
        checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_idle_we: got %0h want 0", bus.rf_we_o); end
    endtask

    task automatic test_bypass();
        bus.mc_valid_i = 1'b1; bus.mc_rd_i = 5'd5; bus.mc_data_i = 32'hAB;
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.rf_we_o !== 1'b1) begin errors++; $display("FAIL bypass_we: got %0h want 1", bus.rf_we_o); end
        checks++; if (bus.rf_rd_o !== 5'd5) begin errors++; $display("FAIL bypass_rd: got %0d want 5", bus.rf_rd_o); end
        checks++; if (bus.rf_data_o !== 32'hAB) begin errors++; $display("FAIL bypass_data: got %0h want ab", bus.rf_data_o); end
        checks++; if (bus.pend_mask_o !== 32'd0) begin errors++; $display("FAIL bypass_pend: got %0h want 0", bus.pend_mask_o); end
        @(negedge clk);
        checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL bypass_idle_we: got %0h want 0", bus.rf_we_o); end
        checks++; if (bus.rf_rd_o !== 5'd5 || bus.rf_data_o !== 32'hAB) begin
            errors++; $display("FAIL bypass_hold: got rd=%0d data=%0h want rd=5 data=ab", bus.rf_rd_o, bus.rf_data_o);
        end
    endtask

    // Fill under constant pipe pressure, wait for the starvation stall, drain.
    task automatic test_full_and_starve();
        logic [4:0] exp_rd [5];
        logic [31:0] exp_mask;
        exp_rd = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
        bus.pipe_we_i = 1'b1; bus.pipe_rd_i = 5'd20; bus.pipe_data_i = 32'h2000;
        for (int k = 1; k <= 4; k++) begin
            bus.mc_valid_i = 1'b1; bus.mc_rd_i = 5'(k); bus.mc_data_i = 32'h1000 + 32'(k);
            @(negedge clk);
            exp_mask = (32'd1 << (k + 1)) - 32'd2;
            checks++; if (bus.rf_we_o !== 1'b1 || bus.rf_rd_o !== 5'd20) begin
                errors++; $display("FAIL fill_pipe_wins k=%0d: got we=%0h rd=%0d want we=1 rd=20", k, bus.rf_we_o, bus.rf_rd_o);
            end
            checks++; if (bus.pend_mask_o !== exp_mask) begin
                errors++; $display("FAIL fill_pend k=%0d: got %0h want %0h", k, bus.pend_mask_o, exp_mask);
            end
        end
        // Fifth result is offered and must be held back while full.
        bus.mc_rd_i = 5'd6; bus.mc_data_i = 32'h1006;
        checks++; if (bus.mc_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %0h want 0", bus.mc_ready_o); end
        repeat (5) @(negedge clk);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL stall_early: got %0h want 0", bus.stall_o); end
        @(negedge clk);
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL stall_assert: got %0h want 1", bus.stall_o); end
        repeat (2) @(negedge clk);
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL stall_hold: got %0h want 1", bus.stall_o); end
        checks++; if (bus.pend_mask_o !== 32'h1E) begin errors++; $display("FAIL full_pend: got %0h want 1e", bus.pend_mask_o); end
        checks++; if (bus.mc_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_hold: got %0h want 0", bus.mc_ready_o); end
        bus.pipe_we_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checks++; if (bus.rf_we_o !== 1'b1 || bus.rf_rd_o !== exp_rd[j] || bus.rf_data_o !== (32'h1000 + 32'(exp_rd[j]))) begin
                errors++; $display("FAIL drain j=%0d: got we=%0h rd=%0d data=%0h want we=1 rd=%0d data=%0h",
                    j, bus.rf_we_o, bus.rf_rd_o, bus.rf_data_o, exp_rd[j], 32'h1000 + 32'(exp_rd[j]));
            end
            if (j == 1) begin
                bus.mc_valid_i = 1'b0;
                checks++; if (bus.pend_mask_o !== 32'h58) begin errors++; $display("FAIL drain_pend: got %0h want 58", bus.pend_mask_o); end
            end
        end
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL stall_last_pop: got %0h want 1", bus.stall_o); end
        @(negedge clk);
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL stall_release: got %0h want 0", bus.stall_o); end
        checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL drain_done_we: got %0h want 0", bus.rf_we_o); end
        idle_inputs();
    endtask

    task automatic test_same_cycle();
        bus.pipe_we_i = 1'b1; bus.pipe_rd_i = 5'd7; bus.pipe_data_i = 32'h77;
        bus.mc_valid_i = 1'b1; bus.mc_rd_i = 5'd9; bus.mc_data_i = 32'h99;
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.rf_we_o !== 1'b1 || bus.rf_rd_o !== 5'd7 || bus.rf_data_o !== 32'h77) begin
            errors++; $display("FAIL same_pipe: got we=%0h rd=%0d data=%0h want we=1 rd=7 data=77", bus.rf_we_o, bus.rf_rd_o, bus.rf_data_o);
        end
        checks++; if (bus.pend_mask_o !== 32'h200) begin errors++; $display("FAIL same_pend: got %0h want 200", bus.pend_mask_o); end
        @(negedge clk);
        checks++; if (bus.rf_we_o !== 1'b1 || bus.rf_rd_o !== 5'd9 || bus.rf_data_o !== 32'h99) begin
            errors++; $display("FAIL same_mc: got we=%0h rd=%0d data=%0h want we=1 rd=9 data=99", bus.rf_we_o, bus.rf_rd_o, bus.rf_data_o);
        end
        checks++; if (bus.pend_mask_o !== 32'd0) begin errors++; $display("FAIL same_pend_clear: got %0h want 0", bus.pend_mask_o); end
    endtask

    task automatic test_x0();
        bus.pipe_we_i = 1'b1; bus.pipe_rd_i = 5'd7; bus.pipe_data_i = 32'h70;
        bus.mc_valid_i = 1'b1; bus.mc_rd_i = 5'd3; bus.mc_data_i = 32'h33;
        @(negedge clk);
        checks++; if (bus.pend_mask_o !== 32'h8) begin errors++; $display("FAIL x0_queued: got %0h want 8", bus.pend_mask_o); end
        bus.pipe_rd_i = 5'd0; bus.pipe_data_i = 32'hDEAD; bus.mc_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.rf_we_o !== 1'b1 || bus.rf_rd_o !== 5'd3 || bus.rf_data_o !== 32'h33) begin
            errors++; $display("FAIL x0_pipe_pop: got we=%0h rd=%0d data=%0h want we=1 rd=3 data=33", bus.rf_we_o, bus.rf_rd_o, bus.rf_data_o);
        end
        checks++; if (bus.pend_mask_o !== 32'd0) begin errors++; $display("FAIL x0_pop_pend: got %0h want 0", bus.pend_mask_o); end
        bus.pipe_we_i = 1'b0;
        bus.mc_valid_i = 1'b1; bus.mc_rd_i = 5'd0; bus.mc_data_i = 32'h55;
        checks++; if (bus.mc_ready_o !== 1'b1) begin errors++; $display("FAIL x0_mc_ready: got %0h want 1", bus.mc_ready_o); end
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.rf_we_o !== 1'b0 || bus.rf_rd_o !== 5'd3) begin
            errors++; $display("FAIL x0_mc_drop: got we=%0h rd=%0d want we=0 rd=3", bus.rf_we_o, bus.rf_rd_o);
        end
        checks++; if (bus.pend_mask_o !== 32'd0) begin errors++; $display("FAIL x0_mc_pend: got %0h want 0", bus.pend_mask_o); end
        @(negedge clk);
        checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL x0_no_late_write: got %0h want 0", bus.rf_we_o); end
    endtask

    task automatic test_reset_mid();
        bus.pipe_we_i = 1'b1; bus.pipe_rd_i = 5'd20; bus.pipe_data_i = 32'h2000;
        for (int k = 10; k <= 12; k++) begin
            bus.mc_valid_i = 1'b1; bus.mc_rd_i = 5'(k); bus.mc_data_i = 32'h3000 + 32'(k);
            @(negedge clk);
        end
        bus.mc_valid_i = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL mid_stall: got %0h want 1", bus.stall_o); end
        checks++; if (bus.pend_mask_o !== 32'h1C00) begin errors++; $display("FAIL mid_pend: got %0h want 1c00", bus.pend_mask_o); end
        reset = 1'b0;
        #1;
        checks++; if (bus.rf_we_o !== 1'b0 || bus.rf_rd_o !== 5'd0 || bus.rf_data_o !== 32'd0) begin
            errors++; $display("FAIL mid_reset_rf: got we=%0h rd=%0d data=%0h want 0 0 0", bus.rf_we_o, bus.rf_rd_o, bus.rf_data_o);
        end
        checks++; if (bus.pend_mask_o !== 32'd0 || bus.stall_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset_state: got pend=%0h stall=%0h want 0 0", bus.pend_mask_o, bus.stall_o);
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        checks++; if (bus.mc_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0h want 1", bus.mc_ready_o); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++; if (bus.rf_we_o !== 1'b0 || bus.pend_mask_o !== 32'd0) begin
                errors++; $display("FAIL mid_stale j=%0d: got we=%0h pend=%0h want 0 0", j, bus.rf_we_o, bus.pend_mask_o);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_bypass();
        test_full_and_starve();
        test_same_cycle();
        test_x0();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
